// File: rtl/regfile_writeback_queue_if.sv
// Writeback request and register-file write bundle shared by producers and the queue.
// master = producer/register-file side, slave = the writeback queue.
interface regfile_writeback_queue_if;
  logic        alu_valid;
  logic [4:0]  alu_wr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_wr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        we;
  logic [4:0]  wr;
  logic [31:0] data;

  modport master (
    output alu_valid, alu_wr, alu_data, mem_valid, mem_wr, mem_data,
    input  alu_ready, mem_ready, we, wr, data
  );

  modport slave (
    input  alu_valid, alu_wr, alu_data, mem_valid, mem_wr, mem_data,
    output alu_ready, mem_ready, we, wr, data
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue (mem before ALU, up to 2 in / 1 out per cycle), head written 1 cycle after accept.
// Readies come from registered count only (mem needs 1 free slot, ALU 2); REGFILE_WB_FWD_EN builds read forwarding.
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  regfile_writeback_queue_if.slave bus,
  input  logic [4:0]               rd1,
  input  logic [4:0]               rd2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [31:0]              fwd1_data,
  output logic [31:0]              fwd2_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] data;
  } entry_t;

  entry_t        slots [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] alu_slot;
  logic [CW-1:0] cnt;
  logic          mem_push;
  logic          alu_push;
  logic          pop;

  assign bus.mem_ready = (cnt <= CW'(DEPTH - 1));
  assign bus.alu_ready = (cnt <= CW'(DEPTH - 2));

  // Writes to r0 complete the handshake but never occupy a slot.
  assign mem_push = !rst && bus.mem_valid && bus.mem_ready && (bus.mem_wr != 5'd0);
  assign alu_push = !rst && bus.alu_valid && bus.alu_ready && (bus.alu_wr != 5'd0);
  assign pop      = (cnt != '0);
  assign alu_slot = tail + PW'(mem_push);

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      head <= head + PW'(pop);
      tail <= tail + PW'(mem_push) + PW'(alu_push);
      cnt  <= cnt + CW'(mem_push) + CW'(alu_push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_push) slots[tail]     <= '{wr: bus.mem_wr, data: bus.mem_data};
    if (alu_push) slots[alu_slot] <= '{wr: bus.alu_wr, data: bus.alu_data};
  end

  assign bus.we   = pop;
  assign bus.wr   = pop ? slots[head].wr   : 5'd0;
  assign bus.data = pop ? slots[head].data : 32'd0;
  assign count    = cnt;

`ifdef REGFILE_WB_FWD_EN
  // Walk oldest to youngest so the last match (youngest) overrides earlier ones.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if (rd1 != 5'd0 && slots[head + PW'(i)].wr == rd1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = slots[head + PW'(i)].data;
        end
        if (rd2 != 5'd0 && slots[head + PW'(i)].wr == rd2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = slots[head + PW'(i)].data;
        end
      end
    end
  end
`else
  logic unused_rd;
  assign unused_rd = ^{rd1, rd2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Cycle-level check of regfile_writeback_queue against a queue-based reference model.
// Directed scenarios first, then randomized producers that hold requests until accepted.
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic [4:0]  rd1, rd2;
  logic        fwd1_hit, fwd2_hit;
  logic [31:0] fwd1_data, fwd2_data;
  logic [$clog2(DEPTH):0] count;

  regfile_writeback_queue_if bus ();

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rd1       (rd1),
    .rd2       (rd2),
    .fwd1_hit  (fwd1_hit),
    .fwd2_hit  (fwd2_hit),
    .fwd1_data (fwd1_data),
    .fwd2_data (fwd2_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  ent_t q[$];
  logic a_v, m_v;
  logic [4:0]  a_wr, m_wr;
  logic [31:0] a_dat, m_dat;
  bit a_acc, m_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_fwd(input logic [4:0] rd, output logic hit, output logic [31:0] dat);
    hit = 1'b0;
    dat = 32'd0;
`ifdef REGFILE_WB_FWD_EN
    if (rd != 5'd0)
      foreach (q[i]) if (q[i].wr == rd) begin
        hit = 1'b1;
        dat = q[i].data;
      end
`endif
  endtask

  // Drive one cycle, check all outputs mid-cycle, then advance the model across the edge.
  task automatic step(input logic r);
    int n;
    logic h1, h2;
    logic [31:0] d1, d2;
    rst = r;
    bus.alu_valid = a_v; bus.alu_wr = a_wr; bus.alu_data = a_dat;
    bus.mem_valid = m_v; bus.mem_wr = m_wr; bus.mem_data = m_dat;
    @(negedge clk);
    n = q.size();
    chk("count",   32'(count), 32'(n));
    chk("mem_rdy", 32'(bus.mem_ready), 32'(n <= DEPTH - 1));
    chk("alu_rdy", 32'(bus.alu_ready), 32'(n <= DEPTH - 2));
    chk("we",      32'(bus.we), 32'(n > 0));
    chk("wr",      32'(bus.wr), (n > 0) ? 32'(q[0].wr) : 32'd0);
    chk("data",    bus.data, (n > 0) ? q[0].data : 32'd0);
    model_fwd(rd1, h1, d1);
    model_fwd(rd2, h2, d2);
    chk("hit1",  32'(fwd1_hit), 32'(h1));
    chk("fdat1", fwd1_data, d1);
    chk("hit2",  32'(fwd2_hit), 32'(h2));
    chk("fdat2", fwd2_data, d2);
    m_acc = !r && m_v && (n <= DEPTH - 1);
    a_acc = !r && a_v && (n <= DEPTH - 2);
    if (r) q.delete();
    else begin
      if (n > 0) void'(q.pop_front());
      if (m_acc && m_wr != 5'd0) q.push_back('{wr: m_wr, data: m_dat});
      if (a_acc && a_wr != 5'd0) q.push_back('{wr: a_wr, data: a_dat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_v = 1'b0; m_v = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rd1 = 5'd0; rd2 = 5'd0;
    a_v = 0; m_v = 0; a_wr = 0; m_wr = 0; a_dat = 0; m_dat = 0;
    bus.alu_valid = 0; bus.alu_wr = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_wr = 0; bus.mem_data = 0;
    repeat (2) @(posedge clk);
    #1;
    step(1'b1);

    // Single ALU write
    a_v = 1; a_wr = 5'd5; a_dat = 32'hDEADBEEF; rd2 = 5'd5;
    step(1'b0);
    idle(); step(1'b0); step(1'b0);

    // Simultaneous mem + ALU to the same register
    m_v = 1; m_wr = 5'd3; m_dat = 32'h11;
    a_v = 1; a_wr = 5'd3; a_dat = 32'h22;
    step(1'b0);
    idle(); rd1 = 5'd3;
    step(1'b0); step(1'b0); step(1'b0);

    // Write to r0 is swallowed
    a_v = 1; a_wr = 5'd0; a_dat = 32'hFFFFFFFF; rd1 = 5'd0;
    step(1'b0);
    idle(); step(1'b0);

    // Continuous backpressure: hold each request until it is taken
    m_v = 1; m_wr = 5'd1; m_dat = 32'h100;
    a_v = 1; a_wr = 5'd2; a_dat = 32'h200;
    rd1 = 5'd1; rd2 = 5'd2;
    for (int i = 0; i < 8; i++) begin
      step(1'b0);
      if (m_acc) m_dat = m_dat + 1;
      if (a_acc) a_dat = a_dat + 1;
    end

    // Reset with entries pending and requests presented
    step(1'b1);
    idle();
    repeat (3) step(1'b0);

    // Randomized traffic with occasional reset
    for (int i = 0; i < 600; i++) begin
      if (m_acc || !m_v) begin
        m_v = ($urandom_range(0, 9) < 6); m_wr = 5'($urandom_range(0, 7)); m_dat = $urandom;
      end
      if (a_acc || !a_v) begin
        a_v = ($urandom_range(0, 9) < 6); a_wr = 5'($urandom_range(0, 7)); a_dat = $urandom;
      end
      rd1 = 5'($urandom_range(0, 7));
      rd2 = 5'($urandom_range(0, 7));
      step($urandom_range(0, 49) == 0);
    end

    idle();
    repeat (5) step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_writeback_queue.md
# regfile_writeback_queue

Write-side front end for the 32×32 register file. It accepts writeback requests from two producers, the ALU path and the memory-load path, over valid/ready handshakes, and buffers them in an in-order queue. It drains one entry per cycle onto the register file's single write port (`we`, `wr`, `data`). While writes are still pending, it optionally supplies read-port forwarding so that readers never see stale register contents.

## Interface
- `DEPTH`, default 4: number of queue entries; power of two, at least 2.
- `clk` input 1: the single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `alu_valid_i` input 1: ALU request valid.
- `alu_wr_i` input 5: ALU destination register.
- `alu_data_i` input 32: ALU result.
- `alu_ready_o` output 1: ALU request is accepted at this edge if valid.
- `mem_valid_i` input 1: load request valid.
- `mem_wr_i` input 5: load destination register.
- `mem_data_i` input 32: load data.
- `mem_ready_o` output 1: load request is accepted at this edge if valid.
- `we_o` output 1: register-file write enable.
- `wr_o` output 5: register-file write address.
- `data_o` output 32: register-file write data.
- `rd1_i`, `rd2_i` input 5 each: read addresses currently presented to the register file.
- `fwd1_hit_o`, `fwd2_hit_o` output 1 each: a pending write to the corresponding read address exists.
- `fwd1_data_o`, `fwd2_data_o` output 32 each: forwarded data; 0 when there is no hit.
- `count_o` output $clog2(DEPTH)+1: number of occupied entries.

## Operation
- **Storage:** circular buffer with head/tail pointers and a count register. Pointers wrap modulo `DEPTH`.
- **Ready signals:** both are functions of the registered count only; there is no combinational path from any valid input.
  - `mem_ready_o` = (count ≤ DEPTH−1).
  - `alu_ready_o` = (count ≤ DEPTH−2).
  - A producer whose valid is high while its ready is low is not accepted. It must hold its request.
- **Enqueue order:** when both producers are accepted in the same cycle, the mem entry is enqueued first (it is older) and the ALU entry second. Up to 2 enqueues per cycle.
- **Register 0:** a request with destination 0 is accepted (handshake completes) but is discarded, not queued.
- **Dequeue:** when count > 0 the head is presented combinationally: `we_o`=1, `wr_o`/`data_o` = head entry. It is popped at the same edge, so the register file writes it at that edge. At most 1 dequeue per cycle.
- **Count update:** next count = count + enqueued − dequeued. The ready rules guarantee count never exceeds DEPTH.
- **Empty queue:** `we_o`=0, `wr_o`=0, `data_o`=0.
- **Forwarding:** for each read port, all occupied entries are searched, including the head being written this cycle.
  - The youngest matching entry wins.
  - A read address of 0 never hits.
  - Same-cycle incoming requests are not searched.

## Timing
- **Reset:** count=0, pointers=0. All outputs then read as follows: `we_o`=0, `wr_o`=0, `data_o`=0, fwd hits 0, fwd data 0, `count_o`=0, `mem_ready_o`=1, `alu_ready_o`=1.
- **Reset mid-operation:** all pending entries are dropped with no write issued. Requests presented in the reset cycle are not accepted.
- **Write latency:** a request accepted at edge N into an empty queue drives `we_o` during cycle N→N+1 and is written to the register file at edge N+1.
- **Ordering:** writes reach the register file in acceptance order, one per cycle. Back-to-back requests to the same register produce the younger value last.
- **Forwarding:** outputs are combinational from queue state and `rdX_i`, valid in the same cycle.

## Configuration
- `REGFILE_WB_FWD_EN` defined: the forwarding search is compiled in as described above.
- Macro undefined: `fwd1_hit_o`, `fwd2_hit_o`, `fwd1_data_o` and `fwd2_data_o` are tied to 0 and no comparators are built. Queue behaviour is otherwise identical.

## Test plan
- **Single write:** reset, then ALU valid with wr=5, data=0xDEADBEEF for one cycle. Next cycle: `we_o`=1, `wr_o`=5, `data_o`=0xDEADBEEF. Following cycle: `we_o`=0 and `count_o`=0.
- **Simultaneous requests:** mem (wr=3, data=0x11) and ALU (wr=3, data=0x22) valid in the same cycle. The write to 3 with 0x11 appears first, then 0x22 next cycle. Forward for rd1=3 returns 0x22 while both entries are pending.
- **Register 0:** ALU valid with wr=0, data=0xFFFFFFFF. The handshake completes, `count_o` stays 0, and `we_o` never asserts.
- **Backpressure (DEPTH=4):** both producers valid continuously. `count_o` goes 0→2→3. `alu_ready_o` drops at count=3 while `mem_ready_o` stays 1. No entry is lost or duplicated.
- **Reset mid-operation:** `rst` asserted with 3 entries pending. Next cycle: `count_o`=0, `we_o`=0, and none of the 3 writes is ever issued.
- **Forwarding disabled:** with `REGFILE_WB_FWD_EN` undefined, repeat the simultaneous-request scenario. Both hits remain 0 and the write sequence is unchanged.
